// File: rtl/dma_pkg.sv
// Shared constants and FSM state type for the AXI4 write DMA.
package dma_pkg;

    localparam int         FIXED_BURST_SIZE = 256;
    localparam int         LOG_BURST_SIZE   = 8;
    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B      = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [3:0] AXI_CACHE_DEF    = 4'b0011;

    typedef enum logic [2:0] {
        WR_IDLE,
        WR_PRE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/dma_wr_len_calc.sv
// Next-burst length (1..256 words) from the remaining word count and current address.
// Optional macro DMA_WR_4K_SPLIT_EN additionally clips the burst at the next 4 KB boundary.
module dma_wr_len_calc
    import dma_pkg::*;
#(
    parameter int BITS_TRANS   = 18,
    parameter int AXI_WIDTH_AD = 32
)(
    input  logic [BITS_TRANS-1:0]   remaining,
    input  logic [AXI_WIDTH_AD-1:0] addr,
    output logic [LOG_BURST_SIZE:0] len
);

    logic [LOG_BURST_SIZE:0] cap;

`ifdef DMA_WR_4K_SPLIT_EN
    // Words left before the next 4 KB page: 1..1024.
    logic [10:0] room;
    logic        unused_addr;

    assign room        = 11'd1024 - {1'b0, addr[11:2]};
    assign cap         = (room > 11'(FIXED_BURST_SIZE)) ? (LOG_BURST_SIZE+1)'(FIXED_BURST_SIZE)
                                                        : room[LOG_BURST_SIZE:0];
    assign unused_addr = ^{addr[AXI_WIDTH_AD-1:12], addr[1:0]};
`else
    logic unused_addr;

    assign cap         = (LOG_BURST_SIZE+1)'(FIXED_BURST_SIZE);
    assign unused_addr = ^addr;
`endif

    always_comb begin
        len = cap;
        if (remaining < {{(BITS_TRANS-LOG_BURST_SIZE-1){1'b0}}, cap})
            len = remaining[LOG_BURST_SIZE:0];
    end

endmodule

// File: rtl/dma_write.sv
// AXI4 write master: drains a 32-bit word stream into DRAM as INCR bursts of up to 256 beats.
// Optional macro DMA_WR_4K_SPLIT_EN keeps every burst inside one 4 KB page.
module dma_write
    import dma_pkg::*;
#(
    parameter int BITS_TRANS   = 18,
    parameter int AXI_WIDTH_ID = 4,
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int AXI_WIDTH_DS = AXI_WIDTH_DA/8
)(
    input  logic                    clk,
    input  logic                    rstn,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [AXI_WIDTH_AD-1:0] M_AXI_AWADDR,
    output logic [AXI_WIDTH_ID-1:0] M_AXI_AWID,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWLOCK,
    output logic [3:0]              M_AXI_AWCACHE,
    output logic [2:0]              M_AXI_AWPROT,
    output logic [3:0]              M_AXI_AWQOS,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    output logic [AXI_WIDTH_DA-1:0] M_AXI_WDATA,
    output logic [AXI_WIDTH_DS-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic [AXI_WIDTH_ID-1:0] M_AXI_BID,
    input  logic                    start_dma,
    input  logic [BITS_TRANS-1:0]   num_trans,
    input  logic [AXI_WIDTH_AD-1:0] start_addr,
    input  logic [AXI_WIDTH_DA-1:0] data_i,
    input  logic                    data_vld_i,
    output logic                    data_rdy_o,
    output logic [BITS_TRANS-1:0]   data_cnt_o,
    output logic                    busy_o,
    output logic                    err_o,
    output logic                    done_o
);

    wr_state_t                 state, next_state;
    logic [BITS_TRANS-1:0]     num_reg, sent, remaining;
    logic [AXI_WIDTH_AD-1:0]   addr;
    logic [LOG_BURST_SIZE:0]   len, len_next, len_m1;
    logic [LOG_BURST_SIZE-1:0] beat;
    logic                      aw_hs, w_hs, b_hs, last_beat;
    logic                      unused_in;

    assign remaining = num_reg - sent;
    assign len_m1    = len - 1'b1;
    assign last_beat = ({1'b0, beat} == len_m1);
    assign aw_hs     = M_AXI_AWVALID & M_AXI_AWREADY;
    assign w_hs      = M_AXI_WVALID & M_AXI_WREADY;
    assign b_hs      = M_AXI_BVALID & M_AXI_BREADY;
    assign unused_in = ^{M_AXI_BID, start_addr[1:0]};

    dma_wr_len_calc #(
        .BITS_TRANS   (BITS_TRANS),
        .AXI_WIDTH_AD (AXI_WIDTH_AD)
    ) u_len_calc (
        .remaining (remaining),
        .addr      (addr),
        .len       (len_next)
    );

    assign M_AXI_AWADDR  = addr;
    assign M_AXI_AWLEN   = len_m1[7:0];
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWSIZE  = AXI_SIZE_4B;
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = AXI_CACHE_DEF;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWQOS   = 4'b1111;
    assign M_AXI_WDATA   = data_i;
    assign M_AXI_WSTRB   = '1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= WR_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state   = state;
        M_AXI_WVALID = 1'b0;
        M_AXI_WLAST  = 1'b0;
        M_AXI_BREADY = 1'b0;
        data_rdy_o   = 1'b0;
        case (state)
            WR_IDLE: if (start_dma) next_state = WR_PRE;
            WR_PRE:  next_state = (sent == num_reg) ? WR_IDLE : WR_ADDR;
            WR_ADDR: if (aw_hs) next_state = WR_DATA;
            WR_DATA: begin
                M_AXI_WVALID = data_vld_i;
                M_AXI_WLAST  = last_beat;
                data_rdy_o   = M_AXI_WREADY;
                if (w_hs && last_beat) next_state = WR_RESP;
            end
            WR_RESP: begin
                M_AXI_BREADY = 1'b1;
                if (b_hs) next_state = WR_PRE;
            end
            default: next_state = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            num_reg       <= '0;
            sent          <= '0;
            addr          <= '0;
            len           <= '0;
            beat          <= '0;
            M_AXI_AWVALID <= 1'b0;
            data_cnt_o    <= '0;
            busy_o        <= 1'b0;
            err_o         <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                WR_IDLE: if (start_dma) begin
                    num_reg    <= num_trans;
                    addr       <= {start_addr[AXI_WIDTH_AD-1:2], 2'b00};
                    sent       <= '0;
                    data_cnt_o <= '0;
                    err_o      <= 1'b0;
                    busy_o     <= 1'b1;
                end
                WR_PRE: begin
                    beat <= '0;
                    if (sent == num_reg) begin
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        len           <= len_next;
                        M_AXI_AWVALID <= 1'b1;
                    end
                end
                WR_ADDR: if (aw_hs) M_AXI_AWVALID <= 1'b0;
                WR_DATA: if (w_hs) begin
                    beat       <= beat + 1'b1;
                    data_cnt_o <= data_cnt_o + 1'b1;
                end
                // Error is only flagged: the burst's data is already consumed, so no retry.
                WR_RESP: if (b_hs) begin
                    if (M_AXI_BRESP != AXI_RESP_OKAY) err_o <= 1'b1;
                    addr <= addr + AXI_WIDTH_AD'({len, 2'b00});
                    sent <= sent + BITS_TRANS'(len);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write.sv
// Scoreboard bench for dma_write: a behavioural AXI slave and stream producer check every AW and W beat.
`timescale 1ns/1ps
module tb_dma_write;

    localparam int BT = 18;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        M_AXI_AWVALID, M_AXI_AWREADY;
    logic [31:0] M_AXI_AWADDR;
    logic [3:0]  M_AXI_AWID;
    logic [7:0]  M_AXI_AWLEN;
    logic [2:0]  M_AXI_AWSIZE;
    logic [1:0]  M_AXI_AWBURST;
    logic        M_AXI_AWLOCK;
    logic [3:0]  M_AXI_AWCACHE;
    logic [2:0]  M_AXI_AWPROT;
    logic [3:0]  M_AXI_AWQOS;
    logic        M_AXI_WVALID, M_AXI_WREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WLAST;
    logic        M_AXI_BVALID, M_AXI_BREADY;
    logic [1:0]  M_AXI_BRESP;
    logic [3:0]  M_AXI_BID;
    logic        start_dma;
    logic [BT-1:0] num_trans;
    logic [31:0] start_addr;
    logic [31:0] data_i;
    logic        data_vld_i, data_rdy_o;
    logic [BT-1:0] data_cnt_o;
    logic        busy_o, err_o, done_o;

    dma_write dut (
        .clk(clk), .rstn(rstn),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA),
        .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_BID(M_AXI_BID),
        .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
        .data_i(data_i), .data_vld_i(data_vld_i), .data_rdy_o(data_rdy_o),
        .data_cnt_o(data_cnt_o), .busy_o(busy_o), .err_o(err_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [39:0] exp_aw[$];   // {awaddr, awlen}
    logic [32:0] exp_w[$];    // {wlast, wdata}

    int          aw_stall, burst_idx, prod_idx, job_id;
    bit          w_rand, v_rand, prod_en, burst_open, b_pending;
    logic [1:0]  resp_tab[8];
    int          bad_w, aw_cycles, aw_wait, done_cnt, done_cyc, b_hs_cyc;
    logic [39:0] aw_first;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int j, input int i);
        return {j[7:0], 8'h5A, i[15:0]};
    endfunction

    // AXI slave + stream producer: drive at negedge, evaluate handshakes 1 ns later.
    initial begin
        logic [39:0] e;
        logic [32:0] ew;
        M_AXI_AWREADY = 1'b0;
        M_AXI_WREADY  = 1'b0;
        M_AXI_BVALID  = 1'b0;
        M_AXI_BRESP   = 2'b00;
        M_AXI_BID     = 4'h0;
        data_vld_i    = 1'b0;
        data_i        = 32'h0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                M_AXI_AWREADY = 1'b0;
                M_AXI_WREADY  = 1'b0;
                M_AXI_BVALID  = 1'b0;
                data_vld_i    = 1'b0;
            end else begin
                M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= aw_stall);
                M_AXI_WREADY  = w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                data_vld_i    = prod_en && (v_rand ? 1'($urandom_range(0, 1)) : 1'b1);
                data_i        = word(job_id, prod_idx);
                M_AXI_BVALID  = b_pending;
                M_AXI_BRESP   = b_pending ? resp_tab[burst_idx % 8] : 2'b00;
                M_AXI_BID     = 4'h3;
                #1;
                if (done_o) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (M_AXI_AWVALID) aw_cycles++;
                if (data_vld_i && data_rdy_o) begin
                    if (!burst_open) bad_w++;
                    if (exp_w.size() == 0) check("w_unexpected", 1, 0);
                    else begin
                        ew = exp_w.pop_front();
                        check("w_beat", {M_AXI_WVALID, M_AXI_WLAST, M_AXI_WDATA}, {1'b1, ew});
                    end
                    prod_idx++;
                    if (M_AXI_WLAST) begin
                        burst_open = 1'b0;
                        b_pending  = 1'b1;
                    end
                end else if (M_AXI_WVALID && M_AXI_WREADY) begin
                    bad_w++;
                end
                if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                    if (b_pending || burst_open) bad_w++;
                    if (exp_aw.size() == 0) check("aw_unexpected", 1, 0);
                    else begin
                        e = exp_aw.pop_front();
                        check("aw_addr_len", {M_AXI_AWADDR, M_AXI_AWLEN}, e);
                    end
                    check("aw_ties",
                          {M_AXI_AWID, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE,
                           M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_WSTRB},
                          {4'h0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b1111, 4'hF});
                    if (aw_wait > 0) check("aw_stable_hs", {M_AXI_AWADDR, M_AXI_AWLEN}, aw_first);
                    aw_wait    = 0;
                    burst_open = 1'b1;
                end else if (M_AXI_AWVALID) begin
                    if (aw_wait == 0) aw_first = {M_AXI_AWADDR, M_AXI_AWLEN};
                    else check("aw_stable", {M_AXI_AWADDR, M_AXI_AWLEN}, aw_first);
                    aw_wait++;
                end
                if (M_AXI_BVALID && M_AXI_BREADY) begin
                    b_pending = 1'b0;
                    burst_idx++;
                    b_hs_cyc  = cyc;
                end
            end
        end
    end

    task automatic run_job(input int n, input logic [31:0] a, input int stall,
                           input bit wr, input bit vr, input logic [1:0] r0, input bit exp_err);
        int          rem, len, k, t, start_cyc;
        logic [31:0] ad;
`ifdef DMA_WR_4K_SPLIT_EN
        int          room;
`endif
        job_id++;
        aw_stall  = stall;
        w_rand    = wr;
        v_rand    = vr;
        for (int i = 0; i < 8; i++) resp_tab[i] = 2'b00;
        resp_tab[0] = r0;
        burst_idx = 0;
        prod_idx  = 0;
        done_cnt  = 0;
        aw_cycles = 0;
        bad_w     = 0;
        rem = n;
        ad  = a & 32'hFFFF_FFFC;
        k   = 0;
        while (rem > 0) begin
            len = (rem > 256) ? 256 : rem;
`ifdef DMA_WR_4K_SPLIT_EN
            room = (4096 - int'(ad[11:0])) / 4;
            if (len > room) len = room;
`endif
            exp_aw.push_back({ad, 8'(len - 1)});
            for (int i = 0; i < len; i++) begin
                exp_w.push_back({(i == len - 1), word(job_id, k)});
                k++;
            end
            ad  = ad + 32'(len * 4);
            rem = rem - len;
        end
        prod_en = 1'b1;
        @(negedge clk);
        start_dma  = 1'b1;
        num_trans  = BT'(n);
        start_addr = a;
        start_cyc  = cyc;
        @(negedge clk);
        start_dma  = 1'b0;
        #2;
        check("busy_set", busy_o, 1);
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        #2;
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (4) @(negedge clk);
        #2;
        check("done_pulses", done_cnt, 1);
        check("data_cnt", data_cnt_o, BT'(n));
        check("busy_clear", busy_o, 0);
        check("err", err_o, exp_err);
        check("aw_left", exp_aw.size(), 0);
        check("w_left", exp_w.size(), 0);
        check("w_protocol", bad_w, 0);
        if (n == 0) begin
            check("aw_none", aw_cycles, 0);
            check("done_latency", done_cyc - start_cyc, 2);
        end else begin
            check("done_latency", done_cyc - b_hs_cyc, 2);
        end
        prod_en = 1'b0;
        exp_aw.delete();
        exp_w.delete();
    endtask

    initial begin
        aw_stall = 0; burst_idx = 0; prod_idx = 0; job_id = 0;
        w_rand = 0; v_rand = 0; prod_en = 0; burst_open = 0; b_pending = 0;
        bad_w = 0; aw_cycles = 0; aw_wait = 0; done_cnt = 0; done_cyc = 0; b_hs_cyc = 0;
        aw_first = '0;
        for (int i = 0; i < 8; i++) resp_tab[i] = 2'b00;
        start_dma = 1'b0; num_trans = '0; start_addr = 32'h0;
        repeat (3) @(negedge clk);
        #2;
        check("reset_outputs",
              {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, data_rdy_o,
               busy_o, err_o, done_o, 32'(data_cnt_o)},
              {8'h00, 32'h0});
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        run_job(600, 32'h1000_0000, 0, 0, 0, 2'b00, 0);
        run_job(40,  32'h2000_0010, 5, 0, 0, 2'b00, 0);
        run_job(17,  32'h3000_0000, 0, 1, 1, 2'b00, 0);
        run_job(300, 32'h4000_0000, 0, 0, 0, 2'b10, 1);
        run_job(0,   32'h5000_0000, 0, 0, 0, 2'b00, 0);
        run_job(5,   32'h6000_0007, 0, 0, 1, 2'b00, 0);
        run_job(256, 32'h0000_0F00, 2, 1, 0, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dma_write.md
Name: dma_write

Overview:
- AXI4 write master that drains a 32-bit word stream from the compute side (output feature maps, results) into DRAM.
- Counterpart of the read DMA. It uses the same start/num_trans/start_addr command style and splits each job into INCR bursts of up to 256 beats.
- Sits between the systolic-array output path and the M00_AXI write channels.

Parameters:
- BITS_TRANS, 18, width of the word count (num_trans, data_cnt_o)
- AXI_WIDTH_ID, 4, AXI ID width
- AXI_WIDTH_AD, 32, address width
- AXI_WIDTH_DA, 32, data width; only 32 is supported
- AXI_WIDTH_DS, AXI_WIDTH_DA/8, strobe width

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- M_AXI_AWVALID/AWREADY  out/in  1  write-address handshake
- M_AXI_AWADDR  out  AXI_WIDTH_AD  burst start address
- M_AXI_AWID  out  AXI_WIDTH_ID  tied to 0
- M_AXI_AWLEN  out  8  beats-1
- M_AXI_AWSIZE  out  3  tied to 3'b010
- M_AXI_AWBURST  out  2  tied to 2'b01 (INCR)
- M_AXI_AWLOCK  out  1  tied to 0
- M_AXI_AWCACHE  out  4  tied to 4'b0011
- M_AXI_AWPROT  out  3  tied to 0
- M_AXI_AWQOS  out  4  tied to 4'b1111
- M_AXI_WVALID/WREADY  out/in  1  write-data handshake
- M_AXI_WDATA  out  AXI_WIDTH_DA  = data_i
- M_AXI_WSTRB  out  AXI_WIDTH_DS  all ones
- M_AXI_WLAST  out  1  last beat of burst
- M_AXI_BVALID/BREADY  in/out  1  response handshake
- M_AXI_BRESP  in  2  response code
- M_AXI_BID  in  AXI_WIDTH_ID  ignored
- start_dma  in  1  one-cycle start pulse
- num_trans  in  BITS_TRANS  number of 32-bit words to write
- start_addr  in  AXI_WIDTH_AD  byte address; bits [1:0] ignored (treated as 0)
- data_i  in  AXI_WIDTH_DA  stream data
- data_vld_i  in  1  stream valid
- data_rdy_o  out  1  stream ready
- data_cnt_o  out  BITS_TRANS  words accepted in the current job
- busy_o  out  1  job in progress
- err_o  out  1  sticky: non-OKAY BRESP seen in the current job
- done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset values: AWVALID, WLAST, BREADY, busy_o, err_o, done_o = 0; data_cnt_o = 0; internal address and counters = 0; state = WR_IDLE.
- FSM states: WR_IDLE, WR_PRE, WR_ADDR, WR_DATA, WR_RESP.
- WR_IDLE: start_dma latches num_trans and start_addr, clears data_cnt_o, err_o and the sent count, sets busy_o, then goes to WR_PRE. start_dma is ignored in every other state.
- WR_PRE: if sent == num_trans, go to WR_IDLE, clear busy_o and register done_o = 1 for one cycle. Otherwise register len = min(256, num_trans - sent) and go to WR_ADDR.
- WR_ADDR: AWVALID is registered and held with AWADDR/AWLEN stable until AWREADY. It is not gated on AWREADY before assertion. On the handshake, go to WR_DATA.
- WR_DATA:
  - WVALID = data_vld_i; data_rdy_o = WREADY. Both are combinational and zero outside WR_DATA.
  - Each WVALID&WREADY beat increments the beat counter and data_cnt_o.
  - WLAST = (beat counter == len-1).
  - The handshake on the last beat moves to WR_RESP.
- WR_RESP: BREADY = 1. On BVALID: if BRESP != 2'b00, set err_o. Then addr += len*4, sent += len, go to WR_PRE. There is no retry, because the data is already consumed.
- Timing: done_o rises two cycles after the final B handshake. With num_trans = 0, done_o rises two cycles after start_dma and no AXI traffic occurs.
- Address and count arithmetic wraps modulo 2^AXI_WIDTH_AD and 2^BITS_TRANS.
- Only one burst is outstanding; AW is never issued before the previous B.
- Reset mid-job aborts immediately. The AXI slave must be reset with it.

Optional Feature:
- Macro: DMA_WR_4K_SPLIT_EN.
- Defined: in WR_PRE, len = min(256, remaining, (4096 - addr[11:0])/4), so no burst crosses a 4 KB boundary.
- Undefined: len = min(256, remaining), and 4 KB alignment of start_addr is the software's responsibility.

Decomposition:
- Package dma_pkg holds: FIXED_BURST_SIZE = 256, LOG_BURST_SIZE, AXI_BURST_INCR, AXI_SIZE_4B, AXI_RESP_OKAY, AXI_CACHE_DEF, and the typedef enum wr_state_t.
- One natural sub-module: dma_wr_len_calc. It is a combinational next-burst-length calculator from remaining count and address, and is the only place the 4K split lives.

Test Plan:
- num_trans = 600, addr 0x1000_0000, always ready → three bursts with AWLEN 255/255/87 at 0x1000_0000/0x1000_0400/0x1000_0800; data_cnt_o ends at 600; one done_o pulse.
- AWREADY held low for 5 cycles → AWVALID, AWADDR and AWLEN stay stable for all 5 cycles; no W beats go out before the handshake.
- data_vld_i and WREADY randomly deasserted (50%), num_trans = 17 → DRAM holds the 17 words in order; WLAST appears only on beat 17.
- BRESP = 2'b10 on burst 1 of 2 → err_o stays set, burst 2 is still issued, done_o still pulses.
- num_trans = 0 → no AWVALID; done_o pulses two cycles after start_dma.
- With DMA_WR_4K_SPLIT_EN defined, addr 0x0000_0F00, num_trans = 256 → two bursts: AWLEN 63 at 0x0F00, then AWLEN 191 at 0x1000.
